// File: rtl/sensor_window_averager.sv
// -----------------------------------------------------------------------------
// sensor_window_averager
//
// Front-end of the ambient controller. Accumulates raw temperature, humidity
// and luminous-intensity samples over a window of N = 2**LOG2_N accepted
// samples. At the end of each window it presents the truncated per-channel
// average to the controller through a valid/ready handshake.
//
// Parameters
//   DATA_WIDTH  temperature width; humidity is DATA_WIDTH+1 bits and
//               luminous intensity is DATA_WIDTH+4 bits
//   LOG2_N      window size exponent, legal range 1..6
//
// Ports
//   clk_i                 clock, all logic on the rising edge
//   reset_i               synchronous reset, active-high
//   enable_i              1 = run; 0 = flush the partial window and idle
//   sample_valid_i        raw sample triple is valid this cycle
//   temperature_raw_i     raw temperature        [DATA_WIDTH-1:0]
//   humidity_raw_i        raw humidity           [DATA_WIDTH:0]
//   luminous_raw_i        raw luminous intensity [DATA_WIDTH+3:0]
//   ready_i               downstream accepts the current average
//   valid_o               output registers hold an unconsumed window
//   temperature_o         averaged temperature
//   humidity_o            averaged humidity
//   luminous_intensity_o  averaged luminous intensity
//   overrun_o             1-cycle pulse: a completed window was dropped
//   overrun_cnt_o         saturating overrun count (OVERRUN_COUNT_EN only)
//   state_o               debug view of the FSM state (IDLE=0, ACCUM=1, HOLD=2)
//
// Build option
//   OVERRUN_COUNT_EN  when defined, adds overrun_cnt_o [7:0]; it counts
//                     overrun_o pulses, saturates at 255 and clears only on
//                     reset_i.
//
// Handshake: a window is transferred on every rising edge where
// valid_o && ready_i. valid_o is registered and, once high, stays high with
// stable data until that transfer happens; ready_i while valid_o=0 is ignored.
// -----------------------------------------------------------------------------
module sensor_window_averager #(
  parameter int DATA_WIDTH = 6,
  parameter int LOG2_N     = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    sample_valid_i,
  input  logic [DATA_WIDTH-1:0]   temperature_raw_i,
  input  logic [DATA_WIDTH:0]     humidity_raw_i,
  input  logic [DATA_WIDTH+3:0]   luminous_raw_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   temperature_o,
  output logic [DATA_WIDTH:0]     humidity_o,
  output logic [DATA_WIDTH+3:0]   luminous_intensity_o,
  output logic                    overrun_o,
`ifdef OVERRUN_COUNT_EN
  output logic [7:0]              overrun_cnt_o,
`endif
  output logic [1:0]              state_o
);

  localparam int TW = DATA_WIDTH;
  localparam int HW = DATA_WIDTH + 1;
  localparam int LW = DATA_WIDTH + 4;
  // Accumulators carry LOG2_N extra bits so N full-scale samples never wrap.
  localparam int TA = TW + LOG2_N;
  localparam int HA = HW + LOG2_N;
  localparam int LA = LW + LOG2_N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [TA-1:0]     temp_acc;
  logic [HA-1:0]     hum_acc;
  logic [LA-1:0]     lum_acc;
  logic [LOG2_N-1:0] count;

  logic [TA-1:0]     temp_sum;
  logic [HA-1:0]     hum_sum;
  logic [LA-1:0]     lum_sum;
  logic              window_done;

  // Sums including the current sample; used both to accumulate and to form
  // the average on the completing sample, so that sample counts toward the
  // window it closes and nothing leaks into the next one.
  assign temp_sum = temp_acc + {{LOG2_N{1'b0}}, temperature_raw_i};
  assign hum_sum  = hum_acc  + {{LOG2_N{1'b0}}, humidity_raw_i};
  assign lum_sum  = lum_acc  + {{LOG2_N{1'b0}}, luminous_raw_i};

  // count holds samples already taken; all ones means this sample is the Nth.
  assign window_done = sample_valid_i && (&count);

  assign state_o = state;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state                <= IDLE;
      temp_acc             <= '0;
      hum_acc              <= '0;
      lum_acc              <= '0;
      count                <= '0;
      valid_o              <= 1'b0;
      temperature_o        <= '0;
      humidity_o           <= '0;
      luminous_intensity_o <= '0;
      overrun_o            <= 1'b0;
`ifdef OVERRUN_COUNT_EN
      overrun_cnt_o        <= '0;
`endif
    end else begin
      overrun_o <= 1'b0;
      if (!enable_i) begin
        // Flush: drop the partial window and any unconsumed output; the data
        // registers keep their last value.
        state    <= IDLE;
        temp_acc <= '0;
        hum_acc  <= '0;
        lum_acc  <= '0;
        count    <= '0;
        valid_o  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // Samples are not taken in the cycle the block wakes up.
            state <= ACCUM;
          end

          ACCUM: begin
            if (window_done) begin
              temperature_o        <= temp_sum[TA-1:LOG2_N];
              humidity_o           <= hum_sum[HA-1:LOG2_N];
              luminous_intensity_o <= lum_sum[LA-1:LOG2_N];
              valid_o              <= 1'b1;
              temp_acc             <= '0;
              hum_acc              <= '0;
              lum_acc              <= '0;
              count                <= '0;
              state                <= HOLD;
            end else if (sample_valid_i) begin
              temp_acc <= temp_sum;
              hum_acc  <= hum_sum;
              lum_acc  <= lum_sum;
              count    <= count + 1'b1;
            end
          end

          HOLD: begin
            if (window_done) begin
              temp_acc <= '0;
              hum_acc  <= '0;
              lum_acc  <= '0;
              count    <= '0;
              if (valid_o && ready_i) begin
                // Old window leaves as the new one arrives: no bubble.
                temperature_o        <= temp_sum[TA-1:LOG2_N];
                humidity_o           <= hum_sum[HA-1:LOG2_N];
                luminous_intensity_o <= lum_sum[LA-1:LOG2_N];
              end else begin
                // Output still owned by the consumer: drop the new window.
                overrun_o <= 1'b1;
`ifdef OVERRUN_COUNT_EN
                if (overrun_cnt_o != 8'hFF) begin
                  overrun_cnt_o <= overrun_cnt_o + 8'd1;
                end
`endif
              end
            end else begin
              if (sample_valid_i) begin
                temp_acc <= temp_sum;
                hum_acc  <= hum_sum;
                lum_acc  <= lum_sum;
                count    <= count + 1'b1;
              end
              if (valid_o && ready_i) begin
                valid_o <= 1'b0;
                state   <= ACCUM;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
